// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed 7-segment display driver. Captures a snapshot of the counter digit
// nibbles and decimal-point requests on LD. It then scans the digits one at a time
// onto a shared, registered SEG/DP bus with per-digit anode enables. Leading-zero
// blanking is optional and is sampled live. SCAN_TC pulses each time the scan
// moves on to the next digit.

module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    C,
  input  logic                    CLR,
  input  logic                    LD,
  input  logic [4*NUM_DIGITS-1:0] D,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic                    BLANK_LZ,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    SCAN_TC
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  // XOR masks that turn the internal active-high form into the pin polarity.
  // Each mask is also the "everything off" value on the pins.
  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

  logic [PRE_W-1:0]          prescaler;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   snap_d;
  logic [NUM_DIGITS-1:0]     snap_dp;
  logic                      scan_adv;

  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic [NUM_DIGITS-1:0]     cur_onehot;
  logic [NUM_DIGITS-1:0]     blank_vec;
  logic                      cur_blank;
  logic [6:0]                seg_ah;
  logic                      dp_ah;
  logic [NUM_DIGITS-1:0]     an_ah;

  // Hex glyph table in active-high {g,f,e,d,c,b,a} form. All 16 codes are defined.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign scan_adv = (prescaler == PRE_LAST);

  // Prescaler and digit index. The index steps on the last prescaler count, and
  // SCAN_TC marks that step. With SCAN_DIV=1 this makes SCAN_TC stay high.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      prescaler <= '0;
      idx       <= '0;
      SCAN_TC   <= 1'b0;
    end else begin
      SCAN_TC <= scan_adv;
      if (scan_adv) begin
        prescaler <= '0;
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Snapshot of the digit nibbles and DP requests. It is only updated on LD.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      snap_d  <= '0;
      snap_dp <= '0;
    end else if (LD) begin
      snap_d  <= D;
      snap_dp <= DP_IN;
    end
  end

  // Leading-zero blanking: a digit goes dark when it and every digit above it are
  // zero, unless that digit asks for its own decimal point. Digit 0 always shows.
  always_comb begin
    logic upper_zero;
    blank_vec  = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero & (snap_d[4*i +: 4] == 4'h0);
      blank_vec[i] = BLANK_LZ & upper_zero & ~snap_dp[i];
    end
  end

  // Select the digit that the current index points at, together with its DP
  // request, its blanking flag and its one-hot anode enable.
  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib       = snap_d[4*i +: 4];
        cur_dp        = snap_dp[i];
        cur_blank     = blank_vec[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // Active-high view of what the next output register values should be.
  always_comb begin
    seg_ah = '0;
    dp_ah  = 1'b0;
    an_ah  = '0;
    if (!cur_blank) begin
      seg_ah = hex_decode(cur_nib);
      dp_ah  = cur_dp;
      an_ah  = cur_onehot;
    end
  end

  // Registered pin drivers. Reset puts every output in its "off" state at the
  // selected polarity.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      SEG <= SEG_OFF;
      DP  <= DP_OFF;
      AN  <= AN_OFF;
    end else begin
      SEG <= seg_ah ^ SEG_OFF;
      DP  <= dp_ah ^ DP_OFF;
      AN  <= an_ah ^ AN_OFF;
    end
  end

endmodule
